// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data memory responder.
//   - req_size encodings (byte / half / word; 2'b11 is illegal)
//   - responder FSM state enum
//   - request capture struct
//   - default storage depth in 32-bit words
package riscv_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int DEPTH_WORDS_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_state_e;

  // Request fields frozen at the accept edge.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_bank_ram.sv
// Single-port word RAM with per-byte write enables.
// Ports:
//   clk   - clock; reads and writes both happen on the rising edge
//   en    - perform an access this edge
//   we    - 1 = write the enabled byte lanes, 0 = read the word into rdata
//   be    - byte-lane write enables (bit i covers bits 8i+7:8i)
//   addr  - word index
//   wdata - write data, already steered to its lanes
//   rdata - registered read data; holds its value while en = 0 or we = 1
// Contents are deliberately not reset.
module dmem_bank_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder for a RISC-V core: one request in flight, three-state
// FSM (IDLE -> ACCESS -> RESP), byte/half/word accesses with sign or zero
// extension on loads and error reporting for bad requests.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   req_valid / req_ready      - request handshake (accepted in IDLE only)
//   req_write, req_addr, req_size, req_unsigned, req_wdata - request fields
//   resp_valid / resp_ready    - response handshake
//   resp_rdata, resp_err       - load data (0 for stores/errors), error flag
//   dbg_state                  - current FSM state for observation
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. The request side is ready only in IDLE; the response side holds
// resp_valid and its payload stable until an edge with resp_ready = 1.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output mem_state_e  dbg_state
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

  mem_state_e  state, state_next;
  mem_req_t    req_q;
  logic        req_err;
  logic [31:0] ram_wdata, ram_rdata;
  logic [3:0]  ram_be;
  logic        ram_en;
  logic [31:0] load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured only on the accept edge, so req_* may change
  // freely while the access is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
    end else if (state == IDLE && req_valid) begin
      req_q <= '{write:       req_write,
                 addr:        req_addr,
                 size:        req_size,
                 is_unsigned: req_unsigned,
                 wdata:       req_wdata};
    end
  end

  // ---------------- error decode ----------------
  always_comb begin
    req_err = 1'b0;
    if (req_q.size == 2'b11)                              req_err = 1'b1;
    if (req_q.size == SIZE_H && req_q.addr[0])            req_err = 1'b1;
    if (req_q.size == SIZE_W && req_q.addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_q.addr[31:2] >= DEPTH_IDX)                    req_err = 1'b1;
  end

  // ---------------- store lane steering ----------------
  // Data is replicated across lanes; the byte enables pick the real target.
  always_comb begin
    ram_wdata = req_q.wdata;
    ram_be    = 4'b1111;
    case (req_q.size)
      SIZE_B: begin
        ram_wdata = {4{req_q.wdata[7:0]}};
        ram_be    = 4'b0001 << req_q.addr[1:0];
      end
      SIZE_H: begin
        ram_wdata = {2{req_q.wdata[15:0]}};
        ram_be    = req_q.addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        ram_wdata = req_q.wdata;
        ram_be    = 4'b1111;
      end
    endcase
  end

  // The RAM acts on the ACCESS -> RESP edge. A reset in ACCESS moves the
  // state to IDLE immediately, which drops ram_en before that edge arrives.
  assign ram_en = (state == ACCESS) && !req_err;

  dmem_bank_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (req_q.write),
    .be    (ram_be),
    .addr  (req_q.addr[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // ---------------- load extraction / extension ----------------
  always_comb begin
    load_byte = ram_rdata[8*req_q.addr[1:0] +: 8];
    load_half = req_q.addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (req_q.size)
      SIZE_B:  load_data = req_q.is_unsigned ? {24'b0, load_byte}
                                             : {{24{load_byte[7]}}, load_byte};
      SIZE_H:  load_data = req_q.is_unsigned ? {16'b0, load_half}
                                             : {{16{load_half[15]}}, load_half};
      default: load_data = ram_rdata;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = req_err;
        if (!req_err && !req_q.write) resp_rdata = load_data;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import riscv_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  mem_state_e  dbg_state;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];   // {err, rdata}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vec_q[$];

  task automatic add(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wd, input logic [31:0] rd,
                     input logic err);
    vec_t v;
    v = '{wr: wr, addr: addr, size: size, uns: uns, wd: wd, rd: rd, err: err};
    vec_q.push_back(v);
  endtask

  // ---------------- driver ----------------
  // One full transaction: present in cycle T, check ACCESS in T+1 while
  // waving junk on req_*, check the response in T+2 and consume it.
  task automatic do_access(input string tag, input vec_t v);
    logic [32:0] exp;
    exp_q.push_back({v.err, v.rd});
    @(negedge clk);
    check({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_write    = v.wr;
    req_addr     = v.addr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_wdata    = v.wd;
    @(negedge clk);
    check({tag, ".t1_valid"}, {31'b0, resp_valid}, 32'd0);
    // Must be ignored: responder is busy.
    req_write = 1'b1;
    req_addr  = 32'h0000_0010;
    req_size  = SIZE_W;
    req_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    exp = exp_q.pop_front();
    check({tag, ".t2_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, ".rdata"}, resp_rdata, exp[31:0]);
    check({tag, ".err"}, {31'b0, resp_err}, {31'b0, exp[32]});
    req_valid  = 1'b0;
    resp_ready = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    check("rst.ready", {31'b0, req_ready}, 32'd1);
    check("rst.valid", {31'b0, resp_valid}, 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.err",   {31'b0, resp_err}, 32'd0);
    check("rst.state", {30'b0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //    wr    addr          size    uns   wdata          exp rdata      err
    add(1'b1, 32'h10,  SIZE_W, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0);
    add(1'b0, 32'h10,  SIZE_W, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0);
    add(1'b1, 32'h11,  SIZE_B, 1'b0, 32'h7F,       32'h0,        1'b0);
    add(1'b0, 32'h11,  SIZE_B, 1'b0, 32'h0,        32'h0000007F, 1'b0);
    add(1'b0, 32'h13,  SIZE_B, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0);
    add(1'b0, 32'h13,  SIZE_B, 1'b1, 32'h0,        32'h000000DE, 1'b0);
    add(1'b0, 32'h10,  SIZE_W, 1'b0, 32'h0,        32'hDEAD7FEF, 1'b0);
    add(1'b1, 32'h20,  SIZE_W, 1'b0, 32'h12345678, 32'h0,        1'b0);
    add(1'b1, 32'h22,  SIZE_H, 1'b0, 32'hFFFF8001, 32'h0,        1'b0);
    add(1'b0, 32'h22,  SIZE_H, 1'b0, 32'h0,        32'hFFFF8001, 1'b0);
    add(1'b0, 32'h22,  SIZE_H, 1'b1, 32'h0,        32'h00008001, 1'b0);
    add(1'b0, 32'h20,  SIZE_W, 1'b0, 32'h0,        32'h80015678, 1'b0);
    add(1'b0, 32'h20,  SIZE_H, 1'b0, 32'h0,        32'h00005678, 1'b0);
    add(1'b0, 32'h23,  SIZE_B, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0);
    add(1'b0, 32'h22,  SIZE_B, 1'b1, 32'h0,        32'h00000001, 1'b0);
    add(1'b1, 32'hFFC, SIZE_W, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0);
    add(1'b0, 32'hFFC, SIZE_W, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0);
    add(1'b0, 32'h12,  SIZE_W, 1'b0, 32'h0,        32'h0,        1'b1);
    add(1'b1, 32'h13,  SIZE_H, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1);
    add(1'b1, 32'h10,  2'b11,  1'b0, 32'hFFFFFFFF, 32'h0,        1'b1);
    add(1'b0, 32'h10,  2'b11,  1'b0, 32'h0,        32'h0,        1'b1);
    add(1'b1, 32'h1000,SIZE_W, 1'b0, 32'h55555555, 32'h0,        1'b1);
    add(1'b1, 32'h1001,SIZE_B, 1'b0, 32'h55,       32'h0,        1'b1);
    add(1'b0, 32'h10,  SIZE_W, 1'b0, 32'h0,        32'hDEAD7FEF, 1'b0);

    for (int i = 0; i < vec_q.size(); i++)
      do_access($sformatf("v%0d", i), vec_q[i]);

    // Response back-pressure: RESP held for 5 cycles.
    @(negedge clk);
    resp_ready   = 1'b0;
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_addr     = 32'h10;
    req_size     = SIZE_W;
    req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d.valid", c), {31'b0, resp_valid}, 32'd1);
      check($sformatf("stall%0d.rdata", c), resp_rdata, 32'hDEAD7FEF);
      check($sformatf("stall%0d.err", c),   {31'b0, resp_err}, 32'd0);
      check($sformatf("stall%0d.ready", c), {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("stall.release", {31'b0, req_ready}, 32'd1);

    // Reset during ACCESS aborts a store.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h10;
    req_size  = SIZE_W;
    req_wdata = 32'h11111111;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort.in_access", {30'b0, dbg_state}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort.state", {30'b0, dbg_state}, 32'd0);
    check("abort.ready", {31'b0, req_ready}, 32'd1);
    check("abort.valid", {31'b0, resp_valid}, 32'd0);
    #1;
    rst = 1'b0;
    do_access("after_abort", '{wr: 1'b0, addr: 32'h10, size: SIZE_W, uns: 1'b0,
                               wd: 32'h0, rd: 32'hDEAD7FEF, err: 1'b0});

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
